// File: rtl/mlu_out_collector.sv
// Collects MLU scalar or 16-lane vector results chunk by chunk and streams
// them word by word into an output buffer through a write port with backpressure.
module mlu_out_collector #(
    parameter int K          = 20,
    parameter int ADDR_W     = 10,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [15:0]       len,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       out_scalar,
    input  logic [15:0][31:0] out_vector,
    output logic [31:0]       count,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CAPTURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    // A legal job never needs more than ceil(K/16) chunks, which bounds the chunk index.
    localparam int CHUNKS = (K + 15) / 16;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int SW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    state_t             state_q;
    logic               scalar_q;
    logic [15:0]        rem_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   count_q;
    logic [SW-1:0]      settle_q;
    logic [3:0]         idx_q;
    logic [3:0]         last_q;
    logic [15:0][31:0]  lane_q;
    logic               err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            scalar_q <= 1'b0;
            rem_q    <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            settle_q <= '0;
            idx_q    <= '0;
            last_q   <= '0;
            lane_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (mode[1]) begin
                            err_q <= 1'b1;
                        end else begin
                            scalar_q <= mode[0];
                            addr_q   <= base_addr;
                            count_q  <= '0;
                            settle_q <= '0;
                            idx_q    <= '0;
                            if (!mode[0] && len == 16'd0) begin
                                rem_q   <= '0;
                                state_q <= S_FINISH;
                            end else begin
                                rem_q   <= mode[0] ? 16'd1 : len;
                                state_q <= S_SETTLE;
                            end
                        end
                    end
                end
                S_SETTLE: begin
                    // Gives the MLU's registered output select time to follow count.
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= '0;
                        state_q  <= S_CAPTURE;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                S_CAPTURE: begin
                    lane_q <= out_vector;
                    if (scalar_q) lane_q[0] <= out_scalar;
                    last_q  <= (rem_q >= 16'd16) ? 4'd15 : rem_q[3:0] - 4'd1;
                    idx_q   <= '0;
                    state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    // wr_en is the valid: it stays high with wr_addr/wr_data frozen
                    // until wr_ready is seen on the same edge; only then does a word move.
                    if (wr_ready) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= (rem_q != 16'd0) ? rem_q - 16'd1 : 16'd0;
                        if (idx_q == last_q) begin
                            idx_q <= '0;
                            if (rem_q > 16'd1) begin
                                count_q <= count_q + CNT_W'(1);
                                state_q <= S_SETTLE;
                            end else begin
                                state_q <= S_FINISH;
                            end
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                S_FINISH: begin
                    count_q <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr_en     = (state_q == S_DRAIN);
    assign wr_addr   = addr_q;
    assign wr_data   = wr_en ? lane_q[idx_q] : 32'd0;
    assign count     = 32'(count_q);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mlu_out_collector.sv
// Bench for mlu_out_collector: directed table of jobs, a mid-drain reset sequence
// and random jobs, all checked against a word-list model of the expected writes.
module tb_mlu_out_collector;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [15:0]       len = 16'd0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [31:0]       out_scalar = 32'd0;
    logic [15:0][31:0] out_vector;
    logic [31:0]       count;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ready = 1'b1;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        dbg_state;

    mlu_out_collector #(.K(20), .ADDR_W(ADDR_W), .SETTLE_CYC(1)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
        .base_addr(base_addr), .out_scalar(out_scalar), .out_vector(out_vector),
        .count(count), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .busy(busy), .done(done), .err(err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // MLU stand-in: output select is registered, lane j of chunk c = seed + 16*c + j.
    logic [31:0] vec_seed = 32'd0;
    logic [31:0] mlu_sel_q = 32'd0;
    always @(posedge clk) mlu_sel_q <= count;
    always_comb begin
        out_vector = '0;
        for (int j = 0; j < 16; j++) out_vector[j] = vec_seed + (mlu_sel_q << 4) + 32'(j);
    end

    int checks = 0;
    int passes = 0;
    logic [73:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic run_job(input logic [1:0] m, input logic [15:0] l, input logic [9:0] b,
                           input logic [31:0] seed, input int bp, input int hold_at,
                           output int n_wr, output int n_done, output int n_err,
                           output logic [9:0] last_a, output bit busy_seen);
        int cyc, post, hold_cnt, first_cyc;
        bit held, timed_out;
        logic [9:0] held_a;
        logic [31:0] held_d;
        logic [73:0] e;
        exp_q.delete();
        if (!m[1]) begin
            if (m[0]) exp_q.push_back({32'd0, b, seed});
            else for (int i = 0; i < int'(l); i++)
                exp_q.push_back({32'(i / 16), 10'(32'(b) + 32'(i)), seed + 32'(i)});
        end
        vec_seed = seed;
        out_scalar = seed;
        n_wr = 0; n_done = 0; n_err = 0; last_a = '0; busy_seen = 0;
        cyc = 0; post = 0; hold_cnt = 0; first_cyc = -1; held = 0; timed_out = 1;
        @(negedge clk);
        start = 1'b1; mode = m; len = l; base_addr = b; wr_ready = 1'b1;
        while (cyc < 1500) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy && $urandom_range(0, 9) == 0) begin
                start = 1'b1; mode = 2'($urandom); len = 16'($urandom); base_addr = 10'($urandom);
            end
            if (hold_at >= 0 && n_wr == hold_at && hold_cnt < 3 && wr_en) begin
                wr_ready = 1'b0; hold_cnt++;
            end else if (hold_at < 0 && bp > 0) begin
                wr_ready = ($urandom_range(0, 99) >= bp);
            end else begin
                wr_ready = 1'b1;
            end
            if (held) begin
                chk("hold_wr_en", 64'(wr_en), 64'd1);
                chk("hold_addr", 64'(wr_addr), 64'(held_a));
                chk("hold_data", 64'(wr_data), 64'(held_d));
                held = 0;
            end
            if (wr_en && first_cyc < 0) first_cyc = cyc;
            if (busy) busy_seen = 1;
            if (done) n_done++;
            if (err) n_err++;
            if (wr_en && wr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL extra_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_count", 64'(count), 64'(e[73:42]));
                    chk("wr_addr", 64'(wr_addr), 64'(e[41:32]));
                    chk("wr_data", 64'(wr_data), 64'(e[31:0]));
                end
                n_wr++;
                last_a = wr_addr;
            end else if (wr_en) begin
                held = 1; held_a = wr_addr; held_d = wr_data;
            end
            if (n_done > 0 || n_err > 0) post++;
            if (post >= 3) begin
                timed_out = 0;
                break;
            end
        end
        start = 1'b0;
        wr_ready = 1'b1;
        chk("job_timeout", 64'(timed_out), 64'd0);
        chk("words_left", 64'(exp_q.size()), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        chk("count_after", 64'(count), 64'd0);
        if (!m[1] && !(m == 2'd0 && l == 16'd0))
            chk("first_wr_latency", 64'(first_cyc), 64'd3);
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [15:0] l;
        logic [9:0]  b;
        logic [31:0] seed;
        int          bp;
        int          hold_at;
        int          e_wr;
        int          e_done;
        int          e_err;
        logic [9:0]  e_last;
        bit          e_busy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n_wr, n_done, n_err, cnt;
        logic [9:0] last_a;
        bit busy_seen;
        logic [1:0] m;
        logic [15:0] l;

        tbl[0] = '{2'd0, 16'd5,  10'd8,    32'd100,        0,  -1, 5,  1, 0, 10'd12,  1'b1};
        tbl[1] = '{2'd0, 16'd20, 10'd0,    32'd0,          0,  -1, 20, 1, 0, 10'd19,  1'b1};
        tbl[2] = '{2'd1, 16'd7,  10'd3,    32'hDEADBEEF,   0,  -1, 1,  1, 0, 10'd3,   1'b1};
        tbl[3] = '{2'd3, 16'd4,  10'd5,    32'd1,          0,  -1, 0,  0, 1, 10'd0,   1'b0};
        tbl[4] = '{2'd0, 16'd0,  10'd9,    32'd1,          0,  -1, 0,  1, 0, 10'd0,   1'b1};
        tbl[5] = '{2'd0, 16'd4,  10'd1022, 32'd7,          0,  -1, 4,  1, 0, 10'd1,   1'b1};
        tbl[6] = '{2'd2, 16'd9,  10'd5,    32'd1,          0,  -1, 0,  0, 1, 10'd0,   1'b0};
        tbl[7] = '{2'd0, 16'd16, 10'd100,  32'h1000,       30, -1, 16, 1, 0, 10'd115, 1'b1};
        tbl[8] = '{2'd0, 16'd32, 10'd1000, 32'h2000,       25, -1, 32, 1, 0, 10'd7,   1'b1};
        tbl[9] = '{2'd0, 16'd10, 10'd50,   32'h300,        0,  4,  10, 1, 0, 10'd59,  1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 10; t++) begin
            run_job(tbl[t].m, tbl[t].l, tbl[t].b, tbl[t].seed, tbl[t].bp, tbl[t].hold_at,
                    n_wr, n_done, n_err, last_a, busy_seen);
            chk($sformatf("t%0d_done", t), 64'(n_done), 64'(tbl[t].e_done));
            chk($sformatf("t%0d_err", t), 64'(n_err), 64'(tbl[t].e_err));
            chk($sformatf("t%0d_writes", t), 64'(n_wr), 64'(tbl[t].e_wr));
            chk($sformatf("t%0d_busy_seen", t), 64'(busy_seen), 64'(tbl[t].e_busy));
            if (tbl[t].e_wr > 0) chk($sformatf("t%0d_last_addr", t), 64'(last_a), 64'(tbl[t].e_last));
        end

        // Reset in the middle of a len=20 drain, then a fresh len=2 job.
        vec_seed = 32'd500;
        @(negedge clk);
        start = 1'b1; mode = 2'd0; len = 16'd20; base_addr = 10'd300; wr_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (wr_en) cnt++;
            if (cnt == 5) break;
        end
        chk("rst_mid_reached_drain", 64'(cnt), 64'd5);
        #2 rst = 1'b0;
        #1;
        chk("rstm_count", 64'(count), 64'd0);
        chk("rstm_wr_en", 64'(wr_en), 64'd0);
        chk("rstm_wr_addr", 64'(wr_addr), 64'd0);
        chk("rstm_wr_data", 64'(wr_data), 64'd0);
        chk("rstm_busy", 64'(busy), 64'd0);
        chk("rstm_done", 64'(done), 64'd0);
        chk("rstm_err", 64'(err), 64'd0);
        chk("rstm_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_job(2'd0, 16'd2, 10'd700, 32'd900, 0, -1, n_wr, n_done, n_err, last_a, busy_seen);
        chk("post_rst_writes", 64'(n_wr), 64'd2);
        chk("post_rst_last_addr", 64'(last_a), 64'd701);
        chk("post_rst_done", 64'(n_done), 64'd1);

        // Random jobs against the model.
        for (int r = 0; r < 12; r++) begin
            m = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            l = 16'($urandom_range(0, 32));
            run_job(m, l, 10'($urandom), $urandom, $urandom_range(0, 50), -1,
                    n_wr, n_done, n_err, last_a, busy_seen);
            chk("rnd_done", 64'(n_done), m[1] ? 64'd0 : 64'd1);
            chk("rnd_err", 64'(n_err), m[1] ? 64'd1 : 64'd0);
            chk("rnd_writes", 64'(n_wr), m[1] ? 64'd0 : (m[0] ? 64'd1 : 64'(l)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mlu_out_collector.md
MLU_OUT_COLLECTOR -- requirements
Module: mlu_out_collector

Interface
- REQ-001: Parameter K, default 20; sort depth of the MLU ksort path; a legal len in vector mode is at most 16*ceil(K/16) words; the block does not check it.
- REQ-002: Parameter ADDR_W, default 10; output-buffer address width.
- REQ-003: Parameter SETTLE_CYC, default 1; cycles waited after each count change before lanes are sampled; covers the registered MLU output select.
- REQ-004: clk  in  1  sole clock; all state updates on the rising edge.
- REQ-005: rst  in  1  asynchronous, active-low reset.
- REQ-006: start  in  1  request pulse; sampled only in IDLE.
- REQ-007: mode  in  2  2'b00 = vector collect, 2'b01 = scalar collect, 2'b1x = illegal.
- REQ-008: len  in  16  number of 32-bit words to collect in vector mode.
- REQ-009: base_addr  in  ADDR_W  first write address.
- REQ-010: out_scalar  in  32  MLU scalar result.
- REQ-011: out_vector[15:0]  in  16x32  MLU vector result chunk.
- REQ-012: count  out  32  chunk index driven to the MLU.
- REQ-013: wr_en  out  1  write request to the output buffer.
- REQ-014: wr_addr  out  ADDR_W  write address.
- REQ-015: wr_data  out  32  write data.
- REQ-016: wr_ready  in  1  buffer accepts the write this cycle.
- REQ-017: busy  out  1  high from start acceptance until done.
- REQ-018: done  out  1  one-cycle completion pulse.
- REQ-019: err  out  1  one-cycle illegal-request pulse.

Function
- REQ-020: FSM states SHALL be IDLE, SETTLE, CAPTURE, DRAIN, FINISH.
- REQ-021: IDLE, start=1, mode legal SHALL latch mode, len and base_addr, set count=0 and busy=1, and go to SETTLE.
  - Exception: vector mode with len=0 goes straight to FINISH.
- REQ-022: IDLE, start=1, mode=2'b1x SHALL pulse err for one cycle next cycle, stay IDLE, and perform no write.
- REQ-023: start while not IDLE SHALL be ignored, and latched parameters SHALL not change.
- REQ-024: SETTLE SHALL last exactly SETTLE_CYC cycles, then go to CAPTURE.
- REQ-025: CAPTURE SHALL last one cycle and latch all 16 out_vector lanes into a local lane register.
  - Scalar mode latches out_scalar into lane 0 instead.
  - Then go to DRAIN.
- REQ-026: In DRAIN, wr_en SHALL be high every cycle; wr_data = current lane; wr_addr = running address.
- REQ-027: A write transfers only on a cycle with wr_en=1 and wr_ready=1.
  - wr_addr and wr_data SHALL hold stable while wr_ready=0.
- REQ-028: Lanes per chunk = min(16, remaining words); scalar mode writes exactly one word.
- REQ-029: The running address SHALL increment by 1 per transfer, modulo 2^ADDR_W.
- REQ-030: After the last lane of a chunk transfers:
  - if words remain, count increments by 1 and the FSM goes to SETTLE;
  - otherwise it goes to FINISH.
- REQ-031: FINISH SHALL last one cycle with done=1; then busy=0, count=0, FSM to IDLE.
- REQ-032: wr_en SHALL be 0 in every state except DRAIN.
- REQ-033: Remaining-word arithmetic SHALL be 16-bit unsigned and never underflow.
- REQ-034: Timing: start sampled at edge E0 with SETTLE_CYC=1 gives first wr_en high after edge E2.

Reset
- REQ-035: rst=0 SHALL immediately force the following, regardless of state, including mid-DRAIN:
  - FSM to IDLE;
  - count=0, wr_en=0, wr_addr=0, wr_data=0;
  - busy=0, done=0, err=0;
  - lane register cleared.
- REQ-036: After rst deasserts, the first accepted start SHALL behave exactly as from power-up; no partial transfer resumes.

Verification
- REQ-037: mode=0, len=5, base=8, wr_ready=1, lanes=100..115 -> 5 writes (8,100) through (12,104); count stays 0; done once; busy low after.
- REQ-038: mode=0, len=20, base=0 -> count 0 for writes 0..15, then count=1 with SETTLE before writes 16..19 (lanes 0..3 of chunk 1); 20 writes total; one done.
- REQ-039: Backpressure: wr_ready held 0 for 3 cycles mid-chunk -> wr_en, wr_addr and wr_data frozen; no lost or duplicated word; total write count unchanged.
- REQ-040: mode=1, out_scalar=32'hDEADBEEF, base=3 -> single write (3, DEADBEEF); count stays 0; done.
- REQ-041: Corner requests:
  - mode=2'b11 -> err pulse, no writes, busy stays 0;
  - mode=0, len=0 -> done pulse, no writes;
  - ADDR_W=10, base=1022, len=4 -> addresses 1022, 1023, 0, 1.
- REQ-042: rst=0 asserted during DRAIN of a len=20 job -> all outputs zero in the same cycle; after release, a new len=2 job writes exactly 2 words starting at its own base_addr.
